simon_autoplayer: RTL and testbench
===================================

Name: simon_autoplayer

Overview:
- Automatic player for the Simon game FSM. It closes the loop on the game's led/btn interface, for self-test and demo.
- Watches the game's one-hot LED playback and records the colour sequence. It then replays the sequence by driving the game's btn inputs.
- Sits beside the game FSM in the same clk domain, between the game's led output and btn input (muxed with the physical buttons at top level).

Parameters:
MAX_LEN, 32, recording depth in steps
PRESS_MS, 50, button hold time per press in ms
END_GAP_MS, 250, LED-dark time that ends a playback in ms
SETTLE_MS, 20, dark time after an echo before the next press in ms
ECHO_TIMEOUT_MS, 1000, maximum wait for an echo LED to turn off

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
ticks_per_milli  in  16  clk cycles per ms minus 1 (same encoding as the game)
enable  in  1  autoplayer active; low forces IDLE
start  in  1  one-cycle pulse; in IDLE it presses btn[0] to start the game
error_inject  in  1  sampled at replay start; corrupts the final replayed step
led  in  4  game LED output
btn  out  4  one-hot button drive to the game
busy  out  1  state != IDLE
round_done  out  1  one-cycle pulse after a full replay completes
seq_len  out  6  number of steps recorded in the current or last round
overflow  out  1  sticky; more than MAX_LEN steps were seen
fault  out  1  sticky; echo timeout

Behaviour:
- Reset: btn=0, busy=0, round_done=0, seq_len=0, overflow=0, fault=0, state=IDLE. All counters and indices are 0.
- ms tick:
  - tick counter counts 0..ticks_per_milli; a ms pulse fires on the cycle it equals ticks_per_milli, then it wraps to 0.
  - ms counter is 10-bit, saturating, and cleared on every state entry.
- led is used as-is, with no synchronizer (same domain). A valid LED means exactly one bit set; 0000 means dark; anything else is invalid.
- Recording memory: MAX_LEN x 2-bit entries, one LED index per step. wr_idx counts recorded steps, rd_idx is the replay position. seq_len = wr_idx.
- enable=0 (any state): next cycle state=IDLE, btn=0, indices cleared. Sticky flags are kept.
- States:
  - IDLE:
    - start & enable -> START_PRESS, btn=0001.
    - enable alone -> LISTEN.
  - START_PRESS: hold btn=0001 for PRESS_MS ms, then btn=0 -> LISTEN.
  - LISTEN (wr_idx=0):
    - valid led -> store index at entry 0, wr_idx=1 -> REC_ON.
    - dark or invalid led -> stay.
  - REC_ON:
    - led dark -> REC_GAP.
    - led changes to any other non-zero value -> discard (wr_idx=0) -> LISTEN.
  - REC_GAP:
    - valid led:
      - if wr_idx==MAX_LEN -> overflow=1 -> IDLE.
      - else store index at wr_idx, wr_idx++ -> REC_ON.
    - invalid led -> discard -> LISTEN.
    - ms counter == END_GAP_MS -> latch error_inject, rd_idx=0 -> REPLAY_PRESS.
  - REPLAY_PRESS:
    - btn = one-hot of the stored index at rd_idx, held PRESS_MS ms, then btn=0 -> WAIT_OFF.
    - If error_inject was latched and rd_idx==wr_idx-1, the driven index is the stored index+1 mod 4.
  - WAIT_OFF:
    - led dark -> SETTLE.
    - ms counter == ECHO_TIMEOUT_MS -> fault=1, btn=0 -> IDLE.
  - SETTLE: after SETTLE_MS ms:
    - if rd_idx+1==wr_idx -> round_done pulse, wr_idx=0 -> LISTEN.
    - else rd_idx++ -> REPLAY_PRESS.
- btn is always 0000 or one-hot, and is never driven outside START_PRESS and REPLAY_PRESS.
- The game's power-on, all-on blinking and game-over patterns are invalid and are never recorded.
- Every playback re-records from index 0, so a round N+1 playback replaces round N.
- start outside IDLE is ignored. error_inject is only sampled at REC_GAP->REPLAY_PRESS.

Decomposition:
- Package simon_pkg holds:
  - state enum;
  - 2-bit colour index typedef;
  - onehot/index conversion functions;
  - shared localparams MAX_GAME_LEN=32 and the game timing constants (300 ms tone, 100 ms gap).
- Sub-module ms_timer:
  - inputs: ticks_per_milli, clear;
  - outputs: ms pulse and saturating 10-bit ms count.
  - It is reused by the game FSM.

Test Plan:
- ticks_per_milli=3. Drive led 0100 for 1200 cycles, dark 400 cycles, then dark 1000 cycles -> seq_len=1; REPLAY btn=0100 for 200 cycles; after the echo model's 300 ms on and SETTLE, round_done pulses once.
- Playback 0001,1000,0010,0001 (300 ms on, 100 ms gap) -> replay btn sequence 0001,1000,0010,0001 in order; no overlap of btn with a pending echo.
- Same 3-step playback with error_inject=1 at replay start -> third press is 0100 instead of 0010; the first two presses are unchanged.
- led goes 1111 mid-recording after 2 steps -> wr_idx cleared, state LISTEN, btn stays 0.
- 33 valid LED flashes without an end gap -> overflow=1, state IDLE, btn=0.
- During replay, the echo LED is held on for 1100 ms -> fault=1 at 1000 ms, IDLE; also assert enable low mid-press -> btn=0 next cycle, busy=0.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game and its autoplayer.
// Contents:
//   MAX_GAME_LEN, TONE_MS, GAP_MS - game-wide sizing and playback timing
//   color_t                        - 2-bit colour index (0..3)
//   ap_state_t                     - autoplayer state encoding
//   idx_to_onehot / onehot_to_idx  - LED/button index conversions
//   onehot_valid                   - exactly one bit set
package simon_pkg;

    localparam int MAX_GAME_LEN = 32;
    localparam int TONE_MS      = 300;
    localparam int GAP_MS       = 100;

    typedef logic [1:0] color_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_PRESS,
        ST_LISTEN,
        ST_REC_ON,
        ST_REC_GAP,
        ST_REPLAY_PRESS,
        ST_WAIT_OFF,
        ST_SETTLE
    } ap_state_t;

    function automatic logic [3:0] idx_to_onehot(color_t idx);
        return 4'b0001 << idx;
    endfunction

    function automatic color_t onehot_to_idx(logic [3:0] oh);
        color_t idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = color_t'(i);
        end
        return idx;
    endfunction

    function automatic logic onehot_valid(logic [3:0] oh);
        return (oh != 4'b0000) && ((oh & (oh - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/simon_autoplayer_if.sv
// Game-facing link between the Simon game FSM and the autoplayer.
// Signals:
//   led - one-hot LED output of the game (dark = 0000)
//   btn - one-hot button drive into the game
// Modports:
//   master - autoplayer side (watches led, drives btn)
//   slave  - game side (drives led, receives btn)
interface simon_autoplayer_if;
    logic [3:0] led;
    logic [3:0] btn;

    modport master (input led, output btn);
    modport slave  (output led, input btn);
endinterface

// File: rtl/ms_timer.sv
// Millisecond timebase: prescaler plus saturating 10-bit ms counter.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   ticks_per_milli - clk cycles per ms minus 1
//   clear           - restart the prescaler and zero the ms count
//   ms_pulse        - high on the last clk cycle of each ms
//   ms_count        - whole ms elapsed since the last clear, saturates
module ms_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_milli,
    input  logic        clear,
    output logic        ms_pulse,
    output logic [9:0]  ms_count
);

    logic [15:0] tick_cnt;

    // Restarting the prescaler on clear makes every state duration an exact
    // multiple of the ms period. The >= guards a ticks_per_milli that drops
    // below the current count at runtime.
    assign ms_pulse = (tick_cnt >= ticks_per_milli);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tick_cnt <= 16'd0;
            ms_count <= 10'd0;
        end else if (ms_pulse) begin
            tick_cnt <= 16'd0;
            if (ms_count != 10'h3FF) ms_count <= ms_count + 10'd1;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/simon_autoplayer.sv
// Simon autoplayer: records the game's LED playback and replays it on btn.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   ticks_per_milli - clk cycles per ms minus 1
//   enable          - low forces IDLE and clears the indices
//   start           - pulse; in IDLE presses btn[0] to start the game
//   error_inject    - sampled at replay start; corrupts the last replayed step
//   game            - led in / btn out to the game FSM
//   busy            - not in IDLE
//   round_done      - one-cycle pulse after a full replay
//   seq_len         - steps recorded so far in this round
//   overflow, fault - sticky: recording overflow, echo timeout
//
// state        | meaning
// IDLE         | inactive, indices cleared
// START_PRESS  | holding btn[0] to start the game
// LISTEN       | waiting for the first LED of a playback
// REC_ON       | a recorded LED is lit
// REC_GAP      | LED dark between steps; long dark ends the playback
// REPLAY_PRESS | driving the button for step rd_idx
// WAIT_OFF     | waiting for the game's echo LED to go dark
// SETTLE       | quiet time before the next press
module simon_autoplayer
    import simon_pkg::*;
#(
    parameter int MAX_LEN         = MAX_GAME_LEN,
    parameter int PRESS_MS        = 50,
    parameter int END_GAP_MS      = 250,
    parameter int SETTLE_MS       = 20,
    parameter int ECHO_TIMEOUT_MS = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         ticks_per_milli,
    input  logic                enable,
    input  logic                start,
    input  logic                error_inject,
    simon_autoplayer_if.master  game,
    output logic                busy,
    output logic                round_done,
    output logic [5:0]          seq_len,
    output logic                overflow,
    output logic                fault
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [5:0] MAX_LEN_W    = 6'(MAX_LEN);
    // A state ends on the ms pulse that completes its last millisecond.
    localparam logic [9:0] PRESS_LAST   = 10'(PRESS_MS - 1);
    localparam logic [9:0] END_GAP_LAST = 10'(END_GAP_MS - 1);
    localparam logic [9:0] SETTLE_LAST  = 10'(SETTLE_MS - 1);
    localparam logic [9:0] ECHO_LAST    = 10'(ECHO_TIMEOUT_MS - 1);

    ap_state_t state, state_next;

    logic [5:0] wr_idx, rd_idx;
    color_t     cur_idx;
    logic       err_lat;
    color_t     mem [MAX_LEN];
    color_t     replay_idx;

    logic       ms_pulse;
    logic [9:0] ms_count;
    logic       timer_clr;

    logic       led_valid, led_dark;
    color_t     led_idx;

    logic wr_en, idx_clr, start_replay, rd_inc;
    logic set_ovf, set_fault, set_done;

    ms_timer u_timer (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (ticks_per_milli),
        .clear           (timer_clr),
        .ms_pulse        (ms_pulse),
        .ms_count        (ms_count)
    );

    assign led_valid = onehot_valid(game.led);
    assign led_dark  = (game.led == 4'b0000);
    assign led_idx   = onehot_to_idx(game.led);
    assign timer_clr = (state_next != state);
    assign busy      = (state != ST_IDLE);
    assign seq_len   = wr_idx;

    always_comb begin
        replay_idx = mem[rd_idx[AW-1:0]];
        if (err_lat && (rd_idx == wr_idx - 6'd1)) replay_idx = replay_idx + 2'd1;
    end

    always_comb begin
        game.btn = 4'b0000;
        case (state)
            ST_START_PRESS:  game.btn = idx_to_onehot(2'd0);
            ST_REPLAY_PRESS: game.btn = idx_to_onehot(replay_idx);
            default:         game.btn = 4'b0000;
        endcase
    end

    always_comb begin
        state_next   = state;
        wr_en        = 1'b0;
        idx_clr      = 1'b0;
        start_replay = 1'b0;
        rd_inc       = 1'b0;
        set_ovf      = 1'b0;
        set_fault    = 1'b0;
        set_done     = 1'b0;
        if (!enable) begin
            state_next = ST_IDLE;
            idx_clr    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    idx_clr    = 1'b1;
                    state_next = start ? ST_START_PRESS : ST_LISTEN;
                end
                ST_START_PRESS: begin
                    if (ms_pulse && ms_count == PRESS_LAST) state_next = ST_LISTEN;
                end
                ST_LISTEN: begin
                    if (led_valid) begin
                        wr_en      = 1'b1;
                        state_next = ST_REC_ON;
                    end
                end
                ST_REC_ON: begin
                    if (led_dark) begin
                        state_next = ST_REC_GAP;
                    end else if (game.led != idx_to_onehot(cur_idx)) begin
                        idx_clr    = 1'b1;
                        state_next = ST_LISTEN;
                    end
                end
                ST_REC_GAP: begin
                    if (led_valid) begin
                        if (wr_idx == MAX_LEN_W) begin
                            set_ovf    = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            wr_en      = 1'b1;
                            state_next = ST_REC_ON;
                        end
                    end else if (!led_dark) begin
                        idx_clr    = 1'b1;
                        state_next = ST_LISTEN;
                    end else if (ms_pulse && ms_count == END_GAP_LAST) begin
                        start_replay = 1'b1;
                        state_next   = ST_REPLAY_PRESS;
                    end
                end
                ST_REPLAY_PRESS: begin
                    if (ms_pulse && ms_count == PRESS_LAST) state_next = ST_WAIT_OFF;
                end
                ST_WAIT_OFF: begin
                    if (led_dark) begin
                        state_next = ST_SETTLE;
                    end else if (ms_pulse && ms_count == ECHO_LAST) begin
                        set_fault  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (ms_pulse && ms_count == SETTLE_LAST) begin
                        if (rd_idx + 6'd1 == wr_idx) begin
                            set_done   = 1'b1;
                            idx_clr    = 1'b1;
                            state_next = ST_LISTEN;
                        end else begin
                            rd_inc     = 1'b1;
                            state_next = ST_REPLAY_PRESS;
                        end
                    end
                end
                default: begin
                    idx_clr    = 1'b1;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx     <= 6'd0;
            rd_idx     <= 6'd0;
            cur_idx    <= 2'd0;
            err_lat    <= 1'b0;
            round_done <= 1'b0;
            overflow   <= 1'b0;
            fault      <= 1'b0;
        end else begin
            round_done <= set_done;
            if (set_ovf)   overflow <= 1'b1;
            if (set_fault) fault    <= 1'b1;
            if (idx_clr) begin
                wr_idx <= 6'd0;
                rd_idx <= 6'd0;
            end else begin
                if (wr_en) begin
                    wr_idx  <= wr_idx + 6'd1;
                    cur_idx <= led_idx;
                end
                if (start_replay) begin
                    rd_idx  <= 6'd0;
                    err_lat <= error_inject;
                end
                if (rd_inc) rd_idx <= rd_idx + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx[AW-1:0]] <= led_idx;
    end

endmodule

// File: tb/tb_simon_autoplayer.sv
// Testbench for simon_autoplayer: game echo model, press monitor, table and
// random playback rounds, plus hand-written corner sequences.
module tb_simon_autoplayer;
    import simon_pkg::*;

    localparam int TPM        = 3;
    localparam int CYC_MS     = TPM + 1;
    localparam int PRESS_CYC  = 50 * CYC_MS;
    localparam int FAULT_CYC  = PRESS_CYC + 1000 * CYC_MS;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ticks_per_milli;
    logic        enable, start, error_inject;
    logic        busy, round_done, overflow, fault;
    logic [5:0]  seq_len;

    simon_autoplayer_if game_if ();

    logic [3:0] play_led = 4'b0000;
    logic [3:0] echo_led = 4'b0000;
    int         echo_cnt = 0;
    int         echo_len = 0;
    bit         echo_en  = 1'b0;

    assign game_if.led = (echo_cnt > 0) ? echo_led : play_led;

    always #5 clk = ~clk;

    simon_autoplayer dut (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (ticks_per_milli),
        .enable          (enable),
        .start           (start),
        .error_inject    (error_inject),
        .game            (game_if),
        .busy            (busy),
        .round_done      (round_done),
        .seq_len         (seq_len),
        .overflow        (overflow),
        .fault           (fault)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Press monitor and game echo model: a press lights the same LED for
    // echo_len cycles starting with the press.
    logic [3:0] press_q [$];
    int         len_q [$];
    logic [3:0] prev_btn    = 4'b0000;
    int         press_len   = 0;
    int         overlap_cnt = 0;
    int         bad_btn_cnt = 0;
    int         done_cnt    = 0;

    always @(negedge clk) begin
        if (round_done) done_cnt++;
        if (echo_cnt > 0) echo_cnt--;
        if (!onehot_valid(game_if.btn) && game_if.btn != 4'b0000) bad_btn_cnt++;
        if (game_if.btn != 4'b0000 && prev_btn == 4'b0000) begin
            if (echo_cnt > 0 || play_led != 4'b0000) overlap_cnt++;
            press_q.push_back(game_if.btn);
            press_len = 1;
            if (echo_en) begin
                echo_led = game_if.btn;
                echo_cnt = echo_len;
            end
        end else if (game_if.btn != 4'b0000) begin
            if (game_if.btn != prev_btn) bad_btn_cnt++;
            press_len++;
        end else if (prev_btn != 4'b0000) begin
            len_q.push_back(press_len);
        end
        prev_btn = game_if.btn;
    end

    // Reference: the replay repeats the playback; with error_inject the last
    // colour moves to the next colour index (wrapping 3 -> 0).
    function automatic logic [15:0] model_replay(logic [15:0] cols, int n, bit err);
        logic [15:0] r;
        logic [3:0]  c;
        r = cols;
        if (err) begin
            c = cols[4*(n-1) +: 4];
            r[4*(n-1) +: 4] = {c[2:0], c[3]};
        end
        return r;
    endfunction

    task automatic clear_mon();
        press_q.delete();
        len_q.delete();
        overlap_cnt = 0;
        bad_btn_cnt = 0;
    endtask

    task automatic play(int n, logic [15:0] cols, int on_c, int gap_c);
        for (int i = 0; i < n; i++) begin
            play_led = cols[4*i +: 4];
            repeat (on_c) @(negedge clk);
            play_led = 4'b0000;
            repeat (gap_c) @(negedge clk);
        end
    endtask

    task automatic run_round(string tag, int n, logic [15:0] cols, bit err,
                             int on_c, int gap_c, int echo_c, logic [15:0] exp);
        int d0, t, bad_len;
        clear_mon();
        d0           = done_cnt;
        echo_len     = echo_c;
        echo_en      = 1'b1;
        error_inject = err;
        play(n, cols, on_c, gap_c);
        check({tag, " seq_len"}, 32'(seq_len), 32'(n));
        t = 0;
        while (done_cnt == d0 && t < 40000) begin
            @(negedge clk);
            t++;
        end
        check({tag, " round_done seen"}, 32'(done_cnt != d0), 32'd1);
        repeat (20) @(negedge clk);
        check({tag, " round_done pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, " press count"}, 32'(press_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < press_q.size())
                check($sformatf("%s press %0d", tag, i), 32'(press_q[i]), 32'(exp[4*i +: 4]));
        end
        bad_len = 0;
        foreach (len_q[i]) if (len_q[i] != PRESS_CYC) bad_len++;
        check({tag, " press durations"}, 32'(bad_len), 32'd0);
        check({tag, " echo overlap"}, 32'(overlap_cnt), 32'd0);
        check({tag, " btn one-hot"}, 32'(bad_btn_cnt), 32'd0);
        error_inject = 1'b0;
    endtask

    typedef struct {
        string       tag;
        int          n;
        logic [15:0] cols;
        bit          err;
        int          on_c;
        int          gap_c;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int t, n;
        logic [15:0] cols;
        bit err;

        vecs[0] = '{"single",    1, 16'h0004, 1'b0, 1200, 400, 16'h0004};
        vecs[1] = '{"four",      4, 16'h1281, 1'b0, 1200, 400, 16'h1281};
        vecs[2] = '{"err3",      3, 16'h0281, 1'b1, 1200, 400, 16'h0481};
        vecs[3] = '{"err_wrap",  2, 16'h0088, 1'b1, 40,   40,  16'h0018};

        rst = 1'b1;
        ticks_per_milli = 16'(TPM);
        enable = 1'b0;
        start = 1'b0;
        error_inject = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset btn", 32'(game_if.btn), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset round_done", 32'(round_done), 32'd0);
        check("reset seq_len", 32'(seq_len), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset fault", 32'(fault), 32'd0);

        // start press from IDLE
        clear_mon();
        enable = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (len_q.size() == 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("start press seen", 32'(len_q.size()), 32'd1);
        if (press_q.size() > 0) check("start press btn", 32'(press_q[0]), 32'h1);
        if (len_q.size() > 0) check("start press len", 32'(len_q[0]), 32'(PRESS_CYC));
        check("start then busy", 32'(busy), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("start ignored outside idle", 32'(press_q.size()), 32'd1);

        // table rounds (echo 300 ms)
        foreach (vecs[i])
            run_round(vecs[i].tag, vecs[i].n, vecs[i].cols, vecs[i].err,
                      vecs[i].on_c, vecs[i].gap_c, 300 * CYC_MS, vecs[i].exp);

        // random rounds checked against the model
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 4);
            cols = 16'h0;
            for (int i = 0; i < n; i++) cols[4*i +: 4] = 4'b0001 << $urandom_range(0, 3);
            err = 1'($urandom_range(0, 1));
            run_round($sformatf("rand%0d", r), n, cols, err, $urandom_range(2, 60),
                      $urandom_range(2, 60), $urandom_range(40, 600), model_replay(cols, n, err));
        end

        // invalid LED after two recorded steps discards the recording
        clear_mon();
        play(2, 16'h0082, 20, 20);
        check("pre-invalid seq_len", 32'(seq_len), 32'd2);
        play_led = 4'b1111;
        @(negedge clk);
        check("invalid seq_len", 32'(seq_len), 32'd0);
        check("invalid busy", 32'(busy), 32'd1);
        check("invalid btn", 32'(game_if.btn), 32'd0);
        repeat (10) @(negedge clk);
        play_led = 4'b0000;
        // a lit LED changing to another pattern also discards
        play(1, 16'h0004, 20, 0);
        play_led = 4'b0001;
        @(negedge clk);
        play_led = 4'b0011;
        @(negedge clk);
        check("change discard seq_len", 32'(seq_len), 32'd0);
        play_led = 4'b0000;
        repeat (1200) @(negedge clk);
        check("invalid no presses", 32'(press_q.size()), 32'd0);
        check("invalid stays empty", 32'(seq_len), 32'd0);

        // overflow on the 33rd step
        for (int i = 0; i < 32; i++) begin
            play_led = 4'b0001 << $urandom_range(0, 3);
            repeat (2) @(negedge clk);
            play_led = 4'b0000;
            repeat (2) @(negedge clk);
        end
        check("full seq_len", 32'(seq_len), 32'd32);
        check("full no overflow", 32'(overflow), 32'd0);
        play_led = 4'b0100;
        @(negedge clk);
        check("overflow flag", 32'(overflow), 32'd1);
        check("overflow idle", 32'(busy), 32'd0);
        check("overflow btn", 32'(game_if.btn), 32'd0);
        enable = 1'b0;
        play_led = 4'b0000;
        repeat (3) @(negedge clk);
        check("overflow sticky", 32'(overflow), 32'd1);
        check("disabled seq_len", 32'(seq_len), 32'd0);
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // enable low in the middle of a replay press
        clear_mon();
        echo_len = 100;
        play(1, 16'h0002, 20, 0);
        t = 0;
        while (game_if.btn == 4'b0000 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("replay press reached", 32'(game_if.btn), 32'h2);
        repeat (50) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("enable low btn", 32'(game_if.btn), 32'd0);
        check("enable low busy", 32'(busy), 32'd0);
        t = 0;
        while (echo_cnt > 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // echo held 1100 ms -> fault at 1000 ms of WAIT_OFF
        clear_mon();
        echo_len = 1100 * CYC_MS;
        play(1, 16'h0008, 20, 0);
        t = 0;
        while (game_if.btn == 4'b0000 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("fault press reached", 32'(game_if.btn), 32'h8);
        t = 0;
        while (!fault && t < 8000) begin
            @(negedge clk);
            t++;
        end
        check("fault flag", 32'(fault), 32'd1);
        check("fault timing", 32'(t), 32'(FAULT_CYC));
        check("fault idle", 32'(busy), 32'd0);
        check("fault btn", 32'(game_if.btn), 32'd0);
        enable = 1'b0;
        t = 0;
        while (echo_cnt > 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("fault sticky", 32'(fault), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failures %0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
